// File: rtl/vc_trace_capture_if.sv
// Readout port of the trace capture buffer: one record per val/rdy handshake.
// The master side (the capture buffer) drives the record; the slave side drives ready.
interface vc_trace_capture_if #(
  parameter int p_msg_nbits = 56
);
  logic                   rd_val;
  logic                   rd_rdy;
  logic [p_msg_nbits-1:0] rd_msg;

  modport master (output rd_val, output rd_msg, input rd_rdy);
  modport slave  (input rd_val, input rd_msg, output rd_rdy);
endinterface

// File: rtl/vc_trace_capture.sv
// Multi-channel en/rdy trace capture: records only active cycles, stamped, into a circular
// buffer under arm/trigger control, then drains them oldest-first over a val/rdy port.
module vc_trace_capture #(
  parameter int p_nchannels  = 4,
  parameter int p_data_nbits = 32,
  parameter int p_depth      = 16,
  parameter int p_post_trig  = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [p_nchannels-1:0]            chan_en,
  input  logic [p_nchannels-1:0]            chan_rdy,
  input  logic [p_nchannels*p_data_nbits-1:0] chan_data,
  input  logic                              arm,
  input  logic                              trig,
  vc_trace_capture_if.master                rd,
  output logic [$clog2(p_depth+1)-1:0]      count,
  output logic [1:0]                        state,
  output logic                              overflow
);

  localparam int c_msg_nbits = 16 + 2*p_nchannels + p_data_nbits;
  localparam int c_ptr_nbits = $clog2(p_depth);
  localparam int c_cnt_nbits = $clog2(p_depth+1);

  typedef enum logic [1:0] {
    st_idle  = 2'b00,
    st_armed = 2'b01,
    st_post  = 2'b10,
    st_dump  = 2'b11
  } state_t;

  state_t                   state_r;
  logic [15:0]              stamp_r;
  logic [c_ptr_nbits-1:0]   wptr_r;
  logic [c_ptr_nbits-1:0]   rptr_r;
  logic [c_cnt_nbits-1:0]   count_r;
  logic [c_cnt_nbits-1:0]   post_cnt_r;
  logic                     overflow_r;
  logic                     rd_val_r;
  logic [c_msg_nbits-1:0]   rd_msg_r;
  logic [c_msg_nbits-1:0]   mem_r [p_depth];

  logic [2*p_nchannels-1:0] code_s;
  logic [p_nchannels-1:0]   fire_s;
  logic [p_data_nbits-1:0]  data_s;
  logic [c_msg_nbits-1:0]   rec_s;
  logic                     active_s;
  logic                     do_write_s;
  logic                     do_pop_s;
  logic                     full_s;
  logic [c_ptr_nbits-1:0]   wptr_nxt_s;
  logic [c_ptr_nbits-1:0]   rptr_nxt_s;
  logic [c_cnt_nbits-1:0]   count_nxt_s;
  logic [c_msg_nbits-1:0]   head_s;

  // Per-channel codes are {en, en ~^ rdy}; data comes from the lowest-indexed firing channel.
  always_comb begin
    code_s = '0;
    fire_s = '0;
    data_s = '0;
    for (int i = 0; i < p_nchannels; i++) begin
      code_s[2*i+1] = chan_en[i];
      code_s[2*i]   = ~(chan_en[i] ^ chan_rdy[i]);
      fire_s[i]     = chan_en[i] & chan_rdy[i];
    end
    for (int i = p_nchannels-1; i >= 0; i--) begin
      data_s = fire_s[i] ? chan_data[i*p_data_nbits +: p_data_nbits] : data_s;
    end
  end

  assign active_s   = |code_s;
  assign rec_s      = {stamp_r, code_s, data_s};
  assign full_s     = (count_r == c_cnt_nbits'(p_depth));
  assign do_write_s = ((state_r == st_armed) || (state_r == st_post)) && active_s;
  assign do_pop_s   = (state_r == st_dump) && rd_val_r && rd.rd_rdy;

  // Next pointer/occupancy values; a write into a full buffer drops the oldest record.
  always_comb begin
    wptr_nxt_s = do_write_s ? wptr_r + c_ptr_nbits'(1) : wptr_r;
    if ((do_write_s && full_s) || do_pop_s) begin
      rptr_nxt_s = rptr_r + c_ptr_nbits'(1);
    end else begin
      rptr_nxt_s = rptr_r;
    end
    if (do_write_s) begin
      count_nxt_s = full_s ? count_r : count_r + c_cnt_nbits'(1);
    end else if (do_pop_s) begin
      count_nxt_s = count_r - c_cnt_nbits'(1);
    end else begin
      count_nxt_s = count_r;
    end
    // Bypass covers the record being written into an empty buffer on the last capture cycle.
    if (do_write_s && (wptr_r == rptr_nxt_s)) begin
      head_s = rec_s;
    end else begin
      head_s = mem_r[rptr_nxt_s];
    end
  end

  // Record storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (do_write_s) begin
      mem_r[wptr_r] <= rec_s;
    end
  end

  // Control FSM with pointers, stamp and registered readout outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= st_idle;
      stamp_r    <= 16'd0;
      wptr_r     <= '0;
      rptr_r     <= '0;
      count_r    <= '0;
      post_cnt_r <= '0;
      overflow_r <= 1'b0;
      rd_val_r   <= 1'b0;
      rd_msg_r   <= '0;
    end else begin
      stamp_r  <= stamp_r + 16'd1;
      wptr_r   <= wptr_nxt_s;
      rptr_r   <= rptr_nxt_s;
      count_r  <= count_nxt_s;
      rd_val_r <= 1'b0;
      rd_msg_r <= '0;
      if (do_write_s && full_s) begin
        overflow_r <= 1'b1;
      end
      case (state_r)
        st_idle: begin
          if (arm) begin
            wptr_r     <= '0;
            rptr_r     <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
            state_r    <= st_armed;
          end
        end
        st_armed: begin
          if (trig) begin
            if (p_post_trig == 0) begin
              state_r  <= st_dump;
              rd_val_r <= (count_nxt_s != '0);
              rd_msg_r <= (count_nxt_s != '0) ? head_s : '0;
            end else begin
              state_r    <= st_post;
              post_cnt_r <= c_cnt_nbits'(p_post_trig);
            end
          end
        end
        st_post: begin
          if (do_write_s) begin
            post_cnt_r <= post_cnt_r - c_cnt_nbits'(1);
            if (post_cnt_r == c_cnt_nbits'(1)) begin
              state_r  <= st_dump;
              rd_val_r <= (count_nxt_s != '0);
              rd_msg_r <= (count_nxt_s != '0) ? head_s : '0;
            end
          end
        end
        st_dump: begin
          if (count_nxt_s == '0) begin
            state_r <= st_idle;
          end else begin
            rd_val_r <= 1'b1;
            rd_msg_r <= head_s;
          end
        end
        default: begin
          state_r <= st_idle;
        end
      endcase
    end
  end

  assign rd.rd_val = rd_val_r;
  assign rd.rd_msg = rd_msg_r;
  assign count     = count_r;
  assign state     = state_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_vc_trace_capture.sv
// Directed bench for vc_trace_capture: stimulus pushes expected records into a queue,
// an independent monitor pops and compares them on every readout handshake.
module tb_vc_trace_capture;

  localparam int c_msg_nbits = 56;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   chan_en;
  logic [3:0]   chan_rdy;
  logic [127:0] chan_data;
  logic         arm;
  logic         trig;
  logic [4:0]   count;
  logic [1:0]   state;
  logic         overflow;
  logic [15:0]  cyc;

  int checks = 0;
  int errors = 0;
  logic [c_msg_nbits-1:0] exp_q[$];
  logic [c_msg_nbits-1:0] mon_exp;

  vc_trace_capture_if #(.p_msg_nbits(c_msg_nbits)) rd_if ();

  vc_trace_capture #(
    .p_nchannels(4), .p_data_nbits(32), .p_depth(16), .p_post_trig(8)
  ) dut (
    .clk(clk), .reset(reset), .chan_en(chan_en), .chan_rdy(chan_rdy),
    .chan_data(chan_data), .arm(arm), .trig(trig), .rd(rd_if),
    .count(count), .state(state), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference cycle stamp: zero on reset, +1 per clock afterwards.
  always @(posedge clk) begin
    if (reset) cyc <= 16'd0;
    else       cyc <= cyc + 16'd1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every handshake must match the oldest expected record.
  always @(negedge clk) begin
    if (!reset && rd_if.rd_val && rd_if.rd_rdy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_msg: unexpected record %h", rd_if.rd_msg);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rd_if.rd_msg !== mon_exp) begin
          errors++;
          $display("FAIL rd_msg: got %h expected %h", rd_if.rd_msg, mon_exp);
        end
      end
    end
  end

  // One stimulus cycle; when rec is set the expected record (with bounded-buffer model) is queued.
  task automatic step(input logic [3:0] en, input logic [3:0] rdy, input logic [127:0] data,
                      input logic a, input logic t, input logic rec,
                      input logic [7:0] codes, input logic [31:0] d);
    chan_en   = en;
    chan_rdy  = rdy;
    chan_data = data;
    arm       = a;
    trig      = t;
    if (rec) begin
      if (exp_q.size() == 16) void'(exp_q.pop_front());
      exp_q.push_back({cyc, codes, d});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fire0(input logic [31:0] d, input logic a, input logic t, input logic rec);
    step(4'b0001, 4'b1111, {96'd0, d}, a, t, rec, 8'h03, d);
  endtask

  task automatic idle(input logic a, input logic t);
    step(4'b0000, 4'b1111, 128'd0, a, t, 1'b0, 8'h00, 32'd0);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (state !== 2'b00 && n < 64) begin
      idle(1'b0, 1'b0);
      n++;
    end
    check({name, "_to_idle"}, state, 2'b00);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_rd_val"}, rd_if.rd_val, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    chan_en = 4'b0000; chan_rdy = 4'b1111; chan_data = 128'd0;
    arm = 1'b0; trig = 1'b0; rd_if.rd_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", state, 2'b00);
    check("rst_count", count, 5'd0);
    check("rst_rd_val", rd_if.rd_val, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_rd_msg", rd_if.rd_msg, 56'd0);
    reset = 1'b0;

    // Activity and trigger without arm: nothing happens.
    for (int k = 0; k < 5; k++) fire0(32'h11 + k, 1'b0, (k == 2), 1'b0);
    check("noarm_state", state, 2'b00);
    check("noarm_count", count, 5'd0);

    // Basic capture; the active arm cycle itself is not recorded.
    fire0(32'hDEAD, 1'b1, 1'b0, 1'b0);
    check("arm_state", state, 2'b01);
    check("arm_count", count, 5'd0);
    for (int k = 0; k < 3; k++) fire0(32'hA0 + k, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1'b1);
    check("trig_state", state, 2'b10);
    check("trig_count", count, 5'd3);
    for (int k = 3; k < 11; k++) fire0(32'hA0 + k, 1'b0, 1'b0, 1'b1);
    check("basic_dump_state", state, 2'b11);
    check("basic_dump_count", count, 5'd11);
    check("basic_rd_val", rd_if.rd_val, 1'b1);
    wait_idle("basic");

    // Overflow: 28 records into a 16-deep buffer, then backpressure before draining.
    rd_if.rd_rdy = 1'b0;
    idle(1'b1, 1'b0);
    for (int k = 1; k <= 20; k++) fire0(32'h100 + k, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1'b1);
    for (int k = 21; k <= 28; k++) fire0(32'h100 + k, 1'b0, 1'b0, 1'b1);
    check("ovf_state", state, 2'b11);
    check("ovf_count", count, 5'd16);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_head", rd_if.rd_msg, exp_q[0]);
    check("ovf_head_data", rd_if.rd_msg[31:0], 32'h10D);
    for (int k = 0; k < 4; k++) begin
      idle(1'b0, 1'b0);
      check("bp_rd_msg", rd_if.rd_msg, exp_q[0]);
      check("bp_count", count, 5'd16);
    end
    rd_if.rd_rdy = 1'b1;
    wait_idle("ovf");
    check("ovf_flag_held", overflow, 1'b1);

    // Idle compression, active trigger cycle, multi-channel encodings, idle cycle in POST.
    idle(1'b1, 1'b0);
    check("rearm_overflow", overflow, 1'b0);
    fire0(32'h40, 1'b0, 1'b0, 1'b1);
    idle(1'b1, 1'b0);
    fire0(32'h42, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1'b0);
    fire0(32'h44, 1'b0, 1'b1, 1'b1);
    check("comp_state", state, 2'b10);
    check("comp_count", count, 5'd3);
    step(4'b1010, 4'b1110, {32'h33, 32'h0, 32'h22, 32'h0}, 1'b0, 1'b1, 1'b1, 8'hCD, 32'h22);
    step(4'b0101, 4'b1011, {32'h0, 32'h77, 32'h0, 32'h55}, 1'b1, 1'b0, 1'b1, 8'h23, 32'h55);
    step(4'b0010, 4'b1101, {32'h0, 32'h0, 32'h99, 32'h0}, 1'b0, 1'b0, 1'b1, 8'h08, 32'h0);
    step(4'b0000, 4'b0111, 128'd0, 1'b0, 1'b0, 1'b1, 8'h40, 32'h0);
    for (int k = 0; k < 3; k++) fire0(32'h50 + k, 1'b0, 1'b1, 1'b1);
    idle(1'b0, 1'b0);
    check("post_idle_state", state, 2'b10);
    fire0(32'h53, 1'b0, 1'b0, 1'b1);
    check("comp_dump_state", state, 2'b11);
    check("comp_dump_count", count, 5'd11);
    wait_idle("comp");

    // Backpressure then reset in the middle of a dump.
    rd_if.rd_rdy = 1'b0;
    idle(1'b1, 1'b0);
    fire0(32'h60, 1'b0, 1'b0, 1'b1);
    fire0(32'h61, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1'b1);
    for (int k = 2; k < 10; k++) fire0(32'h60 + k, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      idle((k == 1), 1'b0);
      check("bp2_state", state, 2'b11);
      check("bp2_count", count, 5'd10);
      check("bp2_rd_val", rd_if.rd_val, 1'b1);
      check("bp2_rd_msg", rd_if.rd_msg, exp_q[0]);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    check("mid_rst_state", state, 2'b00);
    check("mid_rst_rd_val", rd_if.rd_val, 1'b0);
    check("mid_rst_count", count, 5'd0);
    check("mid_rst_rd_msg", rd_if.rd_msg, 56'd0);
    reset = 1'b0;
    idle(1'b0, 1'b0);
    check("post_rst_state", state, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
